// File: rtl/i2c_log_formatter.sv
// Formats buffered I2C register-write records as hex-ASCII lines for a byte UART.
// Optional per-record sequence-number prefix: define I2C_LOG_SEQNUM_EN.
module i2c_log_formatter #(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] SEP_CHAR   = 8'h20,
  parameter bit         EOL_CRLF   = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      address,
  input  logic                            address_ready,
  input  logic [7:0]                      reg_address,
  input  logic                            reg_address_ready,
  input  logic [7:0]                      reg_data,
  input  logic                            reg_data_ready,
  input  logic                            uart_tx_done,
  output logic [7:0]                      uart_tx_data,
  output logic                            uart_tx_en,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH+1);
`ifdef I2C_LOG_SEQNUM_EN
  localparam int NFIELD = 4;
`else
  localparam int NFIELD = 3;
`endif
  localparam int REC_W    = NFIELD * 8;
  localparam int BODY_LEN = 3 * NFIELD - 1;
  localparam int LINE_LEN = BODY_LEN + (EOL_CRLF ? 2 : 1);
  localparam int IDX_W    = 4;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  state_t           state, state_nxt;
  logic [7:0]       addr_q, reg_q;
  logic [7:0]       addr_cur, reg_cur;
  logic [REC_W-1:0] rec_in;
  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] count;
  logic             full, empty, pop, push_ok, drop;
  logic [REC_W-1:0] line_q;
  logic [IDX_W-1:0] idx_q;
  logic             last;

  function automatic logic [7:0] hex_digit(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10) c = 8'h30 + {4'h0, nib};
    else             c = 8'h37 + {4'h0, nib};
    return c;
  endfunction

  // Byte p of the line: fields as "HH" separated by SEP_CHAR, then the end-of-line bytes.
  function automatic logic [7:0] char_at(input logic [REC_W-1:0] line, input logic [IDX_W-1:0] idx);
    int         p;
    int         f;
    logic [7:0] fld;
    logic [7:0] c;
    p   = int'(idx);
    f   = p / 3;
    fld = 8'h00;
    for (int i = 0; i < NFIELD; i++)
      if (i == f) fld = line[REC_W-1-8*i -: 8];
    if (p >= BODY_LEN) begin
      c = (EOL_CRLF && p == BODY_LEN) ? 8'h0D : 8'h0A;
    end else begin
      case (p % 3)
        0:       c = hex_digit(fld[7:4]);
        1:       c = hex_digit(fld[3:0]);
        default: c = SEP_CHAR;
      endcase
    end
    return c;
  endfunction

  // Capture stage: a strobe coincident with reg_data_ready overrides the held byte
  always_ff @(posedge clk) begin
    if (address_ready)     addr_q <= address;
    if (reg_address_ready) reg_q  <= reg_address;
  end

  assign addr_cur = address_ready     ? address     : addr_q;
  assign reg_cur  = reg_address_ready ? reg_address : reg_q;

`ifdef I2C_LOG_SEQNUM_EN
  logic [7:0] seq_q;

  // Counts every completed record, dropped or not, so gaps reveal drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 seq_q <= 8'h00;
    else if (reg_data_ready) seq_q <= seq_q + 8'd1;
  end

  assign rec_in = {seq_q, addr_cur, reg_cur, reg_data};
`else
  assign rec_in = {addr_cur, reg_cur, reg_data};
`endif

  // Record FIFO stage; a simultaneous pop frees the slot for a push while full
  assign full    = (count == LVL_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign pop     = (state == S_IDLE) && !empty;
  assign push_ok = reg_data_ready && (!full || pop);
  assign drop    = reg_data_ready && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rec_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)      count <= count + LVL_W'(1);
      else if (!push_ok && pop) count <= count - LVL_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  assign fifo_level = count;

  // Line stage: popped record held while its bytes are serialised
  always_ff @(posedge clk) begin
    if (pop) line_q <= mem[rd_ptr];
  end

  assign last = (idx_q == IDX_W'(LINE_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               idx_q <= '0;
    else if (pop)                                          idx_q <= '0;
    else if (state == S_WAIT && uart_tx_done && !last)     idx_q <= idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!empty) state_nxt = S_SEND;
      S_SEND:  state_nxt = S_WAIT;
      S_WAIT:  if (uart_tx_done) state_nxt = last ? S_IDLE : S_SEND;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Data is held from SEND through WAIT; zero while idle
  always_comb begin
    uart_tx_en   = (state == S_SEND);
    uart_tx_data = 8'h00;
    if (state != S_IDLE) uart_tx_data = char_at(line_q, idx_q);
  end

endmodule

// File: tb/tb_i2c_log_formatter.sv
// Bench for i2c_log_formatter: DUT a (defaults) and DUT b (depth 4, LF only) share stimulus.
module tb_i2c_log_formatter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] address, reg_address, reg_data;
  logic       address_ready, reg_address_ready, reg_data_ready;
  logic       done_a, done_b, en_a, en_b, ov_a, ov_b;
  logic [7:0] data_a, data_b;
  logic [4:0] lvl_a;
  logic [2:0] lvl_b;
  logic       hold;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] m_addr, m_reg;
`ifdef I2C_LOG_SEQNUM_EN
  logic [7:0] m_seq;
`endif
  int checks = 0;
  int fails  = 0;
  int dcnt_a = 0;

  always #5 clk = ~clk;

  i2c_log_formatter dut_a (
    .clk(clk), .rst(rst),
    .address(address), .address_ready(address_ready),
    .reg_address(reg_address), .reg_address_ready(reg_address_ready),
    .reg_data(reg_data), .reg_data_ready(reg_data_ready),
    .uart_tx_done(done_a), .uart_tx_data(data_a), .uart_tx_en(en_a),
    .overflow(ov_a), .fifo_level(lvl_a)
  );

  i2c_log_formatter #(.FIFO_DEPTH(4), .EOL_CRLF(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .address(address), .address_ready(address_ready),
    .reg_address(reg_address), .reg_address_ready(reg_address_ready),
    .reg_data(reg_data), .reg_data_ready(reg_data_ready),
    .uart_tx_done(done_b), .uart_tx_data(data_b), .uart_tx_en(en_b),
    .overflow(ov_b), .fifo_level(lvl_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hx(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  task automatic push_line(input bit to_b, input logic [7:0] a, input logic [7:0] r, input logic [7:0] d);
    logic [7:0] ln[$];
`ifdef I2C_LOG_SEQNUM_EN
    ln.push_back(hx(m_seq[7:4])); ln.push_back(hx(m_seq[3:0])); ln.push_back(8'h20);
`endif
    ln.push_back(hx(a[7:4])); ln.push_back(hx(a[3:0])); ln.push_back(8'h20);
    ln.push_back(hx(r[7:4])); ln.push_back(hx(r[3:0])); ln.push_back(8'h20);
    ln.push_back(hx(d[7:4])); ln.push_back(hx(d[3:0]));
    if (!to_b) ln.push_back(8'h0D);
    ln.push_back(8'h0A);
    foreach (ln[i]) begin
      if (to_b) qb.push_back(ln[i]);
      else      qa.push_back(ln[i]);
    end
  endtask

  // One-cycle record strobe; caller is 1 time unit after a rising edge
  task automatic send(input bit sa, input logic [7:0] a, input bit sr, input logic [7:0] r,
                      input logic [7:0] d, input bit drop_b);
    address = a; address_ready = sa;
    reg_address = r; reg_address_ready = sr;
    reg_data = d; reg_data_ready = 1'b1;
    if (sa) m_addr = a;
    if (sr) m_reg = r;
    push_line(1'b0, m_addr, m_reg, d);
    if (!drop_b) push_line(1'b1, m_addr, m_reg, d);
`ifdef I2C_LOG_SEQNUM_EN
    m_seq = m_seq + 8'd1;
`endif
    @(posedge clk); #1;
    address_ready = 1'b0; reg_address_ready = 1'b0; reg_data_ready = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (10) @(posedge clk);
    #1;
    chk({tag, "_pending_bytes"}, qa.size() + qb.size(), 0);
    chk({tag, "_lvl_a"}, lvl_a, 0);
    chk({tag, "_lvl_b"}, lvl_b, 0);
  endtask

  // UART model: done returned 5 cycles after each start pulse, deferred while hold is set
  initial begin
    done_a = 1'b0;
    forever begin
      @(posedge clk); #1;
      done_a = 1'b0;
      if (en_a) begin
        repeat (5) @(posedge clk);
        while (hold) @(posedge clk);
        #1 done_a = 1'b1;
      end
    end
  end

  initial begin
    done_b = 1'b0;
    forever begin
      @(posedge clk); #1;
      done_b = 1'b0;
      if (en_b) begin
        repeat (5) @(posedge clk);
        while (hold) @(posedge clk);
        #1 done_b = 1'b1;
      end
    end
  end

  always @(posedge clk) if (done_a) dcnt_a <= dcnt_a + 1;

  // Scoreboard: every transmitted byte must match the head of its queue
  always @(negedge clk) begin
    if (en_a) begin
      chk("a_byte_expected", qa.size() != 0, 1);
      if (qa.size() != 0) chk("a_byte", data_a, qa.pop_front());
    end
    if (en_b) begin
      chk("b_byte_expected", qb.size() != 0, 1);
      if (qb.size() != 0) chk("b_byte", data_b, qb.pop_front());
    end
  end

  initial begin
    int start;
    int n;
    rst = 1'b1; hold = 1'b0;
    address = 8'h00; reg_address = 8'h00; reg_data = 8'h00;
    address_ready = 1'b0; reg_address_ready = 1'b0; reg_data_ready = 1'b0;
    m_addr = 8'h00; m_reg = 8'h00;
`ifdef I2C_LOG_SEQNUM_EN
    m_seq = 8'h00;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en_a", en_a, 0);
    chk("rst_data_a", data_a, 0);
    chk("rst_ov_a", ov_a, 0);
    chk("rst_lvl_a", lvl_a, 0);
    chk("rst_en_b", en_b, 0);
    chk("rst_lvl_b", lvl_b, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single record, latency of first start pulse
    send(1'b1, 8'hA0, 1'b1, 8'h10, 8'h5A, 1'b0);
    chk("lat_n1_en_a", en_a, 0);
    chk("lat_n1_lvl_a", lvl_a, 1);
    chk("lat_n1_lvl_b", lvl_b, 1);
    @(posedge clk); #1;
    chk("lat_n2_en_a", en_a, 1);
    chk("lat_n2_en_b", en_b, 1);
    chk("lat_n2_lvl_a", lvl_a, 0);
    chk("lat_n2_first_a", data_a, hx(4'hA));
    wait_drain("single");

    // Auto-increment: data-only strobe reuses held address and register
    send(1'b1, 8'hA0, 1'b1, 8'h10, 8'h01, 1'b0);
    send(1'b0, 8'hFF, 1'b0, 8'hFF, 8'h02, 1'b0);
    wait_drain("autoinc");

    // Same-cycle strobes override held values
    send(1'b1, 8'h3C, 1'b1, 8'h7E, 8'hC3, 1'b0);
    send(1'b0, 8'h00, 1'b1, 8'h55, 8'h99, 1'b0);
    send(1'b1, 8'h12, 1'b0, 8'h00, 8'h34, 1'b0);
    wait_drain("override");

    // Overflow: UART stalled, six back-to-back records; DUT b drops the sixth
    hold = 1'b1;
    send(1'b1, 8'h50, 1'b1, 8'h20, 8'h11, 1'b0);
    send(1'b0, 8'h00, 1'b0, 8'h00, 8'h12, 1'b0);
    send(1'b0, 8'h00, 1'b0, 8'h00, 8'h13, 1'b0);
    send(1'b0, 8'h00, 1'b0, 8'h00, 8'h14, 1'b0);
    send(1'b0, 8'h00, 1'b0, 8'h00, 8'h15, 1'b0);
    send(1'b0, 8'h00, 1'b0, 8'h00, 8'h16, 1'b1);
    @(posedge clk); #1;
    chk("ovf_ov_b", ov_b, 1);
    chk("ovf_lvl_b", lvl_b, 4);
    chk("ovf_ov_a", ov_a, 0);
    chk("ovf_lvl_a", lvl_a, 5);
    hold = 1'b0;
    wait_drain("overflow");
    send(1'b0, 8'h00, 1'b0, 8'h00, 8'h17, 1'b0);
    wait_drain("after_ovf");
    chk("ovf_sticky_b", ov_b, 1);

    // Reset mid-line after the third byte completes
    send(1'b1, 8'hC0, 1'b1, 8'h44, 8'hEE, 1'b0);
    start = dcnt_a;
    n = 0;
    while (dcnt_a < start + 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midline_done_seen", dcnt_a >= start + 3, 1);
    rst = 1'b1;
    qa.delete();
    qb.delete();
    m_addr = 8'h00; m_reg = 8'h00;
`ifdef I2C_LOG_SEQNUM_EN
    m_seq = 8'h00;
`endif
    @(posedge clk); #1;
    chk("mrst_en_a", en_a, 0);
    chk("mrst_en_b", en_b, 0);
    chk("mrst_lvl_a", lvl_a, 0);
    chk("mrst_ov_a", ov_a, 0);
    chk("mrst_ov_b", ov_b, 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    send(1'b1, 8'h7F, 1'b1, 8'h08, 8'hB2, 1'b0);
    wait_drain("post_reset");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
